// File: rtl/rand_uart_tx.sv
// 8N1 UART transmitter for the chaotic generator's byte stream.
// It accepts one byte per valid/ready handshake and sends it LSB first at clk_i/BaudDiv baud.
module rand_uart_tx #(
  parameter int BaudDiv = 434,
  parameter int Width   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int CntW = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam int BitW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(BaudDiv - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(Width - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       r_state;
  logic [CntW-1:0]  r_baud;
  logic [BitW-1:0]  r_bit;
  logic [Width-1:0] r_shift;
  logic             r_tx;
  logic             r_ready;
  logic             r_busy;
  logic             w_tick;
  logic             w_take;

  always_comb begin
    w_tick = (r_baud == LastCnt);
    w_take = valid_i & r_ready;
  end

  // tx_o is registered, so each edge loads the level for the coming bit period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (w_take) begin
            r_shift <= data_i;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_baud  <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + CntW'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_baud <= '0;
            if (r_bit == LastBit) begin
              r_bit   <= '0;
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              // Bit 1 of the pre-shift value becomes bit 0 after the shift.
              r_shift <= {1'b0, r_shift[Width-1:1]};
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + BitW'(1);
            end
          end else begin
            r_baud <= r_baud + CntW'(1);
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_baud <= r_baud + CntW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_bit   <= '0;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o    = r_tx;
  assign ready_o = r_ready;
  assign busy_o  = r_busy;

endmodule
